// File: rtl/addr_gen_2d.sv
// Two-dimensional row-major address walker for matrix tiles.
// Issues one address per valid/ready transfer, flags the final element and pulses done.
module addr_gen_2d #(
  parameter int AW = 16,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [CW-1:0] rows,
  input  logic [CW-1:0] cols,
  input  logic [AW-1:0] stride,
  output logic [AW-1:0] addr_out,
  output logic          addr_valid,
  input  logic          addr_ready,
  output logic [CW-1:0] row_idx,
  output logic [CW-1:0] col_idx,
  output logic          last,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] row_base_q, row_base_d;
  logic [AW-1:0] stride_q, stride_d;
  logic [CW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [CW-1:0] rows_q, rows_d;
  logic [CW-1:0] cols_q, cols_d;
  logic          row_end, col_end, accept;

  // Address sums wrap modulo 2^AW; no saturation.
  function automatic logic [AW-1:0] addr_add(input logic [AW-1:0] a, input logic [AW-1:0] b);
    return a + b;
  endfunction

  assign row_end = (row_q == rows_q - CW'(1));
  assign col_end = (col_q == cols_q - CW'(1));
  assign accept  = (state_q != RUN) && start;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    row_base_d = row_base_q;
    stride_d   = stride_q;
    row_d      = row_q;
    col_d      = col_q;
    rows_d     = rows_q;
    cols_d     = cols_q;
    unique case (state_q)
      RUN: begin
        if (addr_ready) begin
          if (!col_end) begin
            col_d  = col_q + CW'(1);
            addr_d = addr_add(addr_q, AW'(1));
          end else if (!row_end) begin
            col_d      = '0;
            row_d      = row_q + CW'(1);
            row_base_d = addr_add(row_base_q, stride_q);
            addr_d     = row_base_d;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A start seen in IDLE or DONE launches a walk; zero-sized tiles finish immediately.
    if (accept) begin
      rows_d     = rows;
      cols_d     = cols;
      stride_d   = stride;
      row_base_d = base;
      addr_d     = base;
      row_d      = '0;
      col_d      = '0;
      state_d    = (rows == '0 || cols == '0) ? DONE : RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  // Tile configuration only matters while walking, so it carries no reset.
  always_ff @(posedge clk) begin
    row_base_q <= row_base_d;
    stride_q   <= stride_d;
    rows_q     <= rows_d;
    cols_q     <= cols_d;
  end

  assign addr_out   = addr_q;
  assign row_idx    = row_q;
  assign col_idx    = col_q;
  assign addr_valid = (state_q == RUN);
  assign last       = (state_q == RUN) && row_end && col_end;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);

endmodule

// File: tb/tb_addr_gen_2d.sv
// Bench for addr_gen_2d: a tile-expansion model predicts every issued address and the
// done/busy timing, plus literal address lists for the directed tiles.
module tb_addr_gen_2d;
  localparam int AW = 16;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base = '0;
  logic [CW-1:0] rows = '0;
  logic [CW-1:0] cols = '0;
  logic [AW-1:0] stride = '0;
  logic          addr_ready = 1'b1;
  logic [AW-1:0] addr_out;
  logic          addr_valid;
  logic [CW-1:0] row_idx;
  logic [CW-1:0] col_idx;
  logic          last, busy, done;

  typedef struct {
    logic [AW-1:0] a;
    int            r;
    int            c;
    bit            l;
  } exp_t;

  exp_t          exp_q[$];
  logic [AW-1:0] log_a[$];
  bit            log_l[$];
  int errors = 0, checks = 0;
  int cyc = 0, done_at = -1, pops = 0;
  int ready_mode = 0, rpat = 0;
  bit chk_en = 1'b0;

  addr_gen_2d #(.AW(AW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .base(base), .rows(rows), .cols(cols),
    .stride(stride), .addr_out(addr_out), .addr_valid(addr_valid),
    .addr_ready(addr_ready), .row_idx(row_idx), .col_idx(col_idx),
    .last(last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ready pattern: constant 1, or repeating 1,0,0
  always @(posedge clk) begin
    #1;
    if (ready_mode == 0) addr_ready = 1'b1;
    else begin
      addr_ready = (rpat % 3 == 0);
      rpat++;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Per-cycle comparison against the model; transfers are decided by the model's own valid.
  always @(negedge clk) begin
    bit   ev;
    exp_t e;
    if (chk_en) begin
      ev = (exp_q.size() != 0);
      chk("addr_valid", {63'd0, addr_valid}, {63'd0, ev});
      chk("done", {63'd0, done}, {63'd0, (cyc == done_at)});
      chk("busy", {63'd0, busy}, {63'd0, (ev || cyc == done_at)});
      if (ev) begin
        e = exp_q[0];
        chk("addr_out", {48'd0, addr_out}, {48'd0, e.a});
        chk("row_idx", {56'd0, row_idx}, 64'(e.r));
        chk("col_idx", {56'd0, col_idx}, 64'(e.c));
        chk("last", {63'd0, last}, {63'd0, e.l});
        if (addr_ready) begin
          log_a.push_back(addr_out);
          log_l.push_back(last);
          if (e.l) done_at = cyc + 1;
          void'(exp_q.pop_front());
          pops++;
        end
      end
    end
  end

  // Drive a start for one edge and expand the tile into the expected address list.
  task automatic launch(input logic [AW-1:0] b, input int r, input int c, input logic [AW-1:0] s);
    exp_t e;
    base = b; rows = CW'(r); cols = CW'(c); stride = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    base = AW'($urandom); rows = CW'($urandom); cols = CW'($urandom); stride = AW'($urandom);
    for (int rr = 0; rr < r; rr++)
      for (int cc = 0; cc < c; cc++) begin
        e.a = AW'(int'(b) + rr * int'(s) + cc);
        e.r = rr;
        e.c = cc;
        e.l = (rr == r - 1) && (cc == c - 1);
        exp_q.push_back(e);
      end
    if (r == 0 || c == 0) done_at = cyc;
  endtask

  task automatic wait_done(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_done: no done pulse within %0d cycles", budget);
    end
  endtask

  task automatic chk_log(input string name, input logic [AW-1:0] lit[$], input int last_pos);
    chk({name, "_count"}, 64'(log_a.size()), 64'(lit.size()));
    for (int i = 0; i < lit.size() && i < log_a.size(); i++) begin
      chk({name, "_addr"}, {48'd0, log_a[i]}, {48'd0, lit[i]});
      chk({name, "_last"}, {63'd0, log_l[i]}, {63'd0, (i == last_pos)});
    end
    log_a.delete();
    log_l.delete();
  endtask

  initial begin
    logic [AW-1:0] lit1[$];
    logic [AW-1:0] litw[$];
    logic [AW-1:0] litb[$];
    int t0;
    lit1 = '{16'h0100, 16'h0101, 16'h0102, 16'h0110, 16'h0111, 16'h0112};
    litw = '{16'hFFFE, 16'hFFFF, 16'h0001, 16'h0002};
    litb = '{16'h0300, 16'h0301};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_addr", {48'd0, addr_out}, 64'd0);
    chk("rst_row", {56'd0, row_idx}, 64'd0);
    chk("rst_col", {56'd0, col_idx}, 64'd0);
    chk("rst_last", {63'd0, last}, 64'd0);

    // Basic 2x3 tile, ready held high
    launch(16'h0100, 2, 3, 16'h0010);
    wait_done(20);
    chk_log("tile_basic", lit1, 5);
    repeat (2) @(negedge clk);

    // Same tile with ready toggling 1,0,0
    ready_mode = 1; rpat = 0;
    launch(16'h0100, 2, 3, 16'h0010);
    wait_done(60);
    chk_log("tile_stall", lit1, 5);
    ready_mode = 0;
    repeat (2) @(negedge clk);

    // Zero-row tile: done exactly one cycle after start, no addresses
    launch(16'h0500, 0, 5, 16'h0010);
    t0 = cyc;
    wait_done(5);
    chk("zero_latency", 64'(cyc - t0), 64'd0);
    chk("zero_count", 64'(log_a.size()), 64'd0);
    repeat (2) @(negedge clk);

    // Mid-run start is ignored, then reset after the third transfer
    launch(16'h0200, 2, 3, 16'h0010);
    start = 1'b1; base = 16'h9000; rows = 8'd4; cols = 8'd4; stride = 16'h0100;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 20 && pops < 3; i++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    done_at = -1;
    @(negedge clk);
    chk("midrst_addr", {48'd0, addr_out}, 64'd0);
    chk("midrst_row", {56'd0, row_idx}, 64'd0);
    chk("midrst_col", {56'd0, col_idx}, 64'd0);
    chk("midrst_valid", {63'd0, addr_valid}, 64'd0);
    chk("midrst_done", {63'd0, done}, 64'd0);
    log_a.delete(); log_l.delete();
    repeat (3) @(negedge clk);

    // Modulo wrap after reset
    launch(16'hFFFE, 2, 2, 16'h0003);
    wait_done(20);
    chk_log("tile_wrap", litw, 3);
    repeat (2) @(negedge clk);

    // Back-to-back: new start during the DONE cycle
    launch(16'h0100, 2, 3, 16'h0010);
    wait_done(20);
    launch(16'h0300, 1, 2, 16'h0040);
    chk("b2b_valid", {63'd0, addr_valid}, 64'd1);
    chk("b2b_addr", {48'd0, addr_out}, 64'h0300);
    wait_done(20);
    void'(log_a.pop_front()); void'(log_a.pop_front()); void'(log_a.pop_front());
    void'(log_a.pop_front()); void'(log_a.pop_front()); void'(log_a.pop_front());
    repeat (6) void'(log_l.pop_front());
    chk_log("tile_b2b", litb, 1);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
